bomb_module: RTL and testbench
==============================

// Module: bomb_module
// PURPOSE
//  Downstream consumer of the bomberman sprite position (x_b, y_b).
//  On a bomb-button press, drops one bomb on the 16x16 arena tile under bomberman's hitbox centre,
//  runs a fuse timer, then shows a cross-shaped explosion.
//  Drives pixel-on flags and colour for the top-level VGA mux, and explosion status for game_lives.
// PARAMETERS
//  FUSE_CNT   150_000_000  clock cycles from drop to explosion
//  EXP_CNT    50_000_000   clock cycles the explosion is displayed
//  EXP_LEN    2            explosion arm length in tiles (each direction)
//  BOMB_RGB   12'h222      bomb colour, phase 0
//  FLASH_RGB  12'hF00      bomb colour, phase 1
//  EXP_RGB    12'hFA0      explosion colour
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  x, y         in   10  current VGA pixel
//  x_b, y_b     in   10  bomberman sprite top-left corner (arena coordinates)
//  bomb_btn     in   1   controller bomb button, level, synchronous to clk
//  gameover     in   1   game lives == 0
//  bomb_on      out  1   pixel is inside the bomb tile (FUSE only)
//  exp_on       out  1   pixel is inside the explosion cross (EXPLODE only)
//  bomb_active  out  1   state == FUSE (registered)
//  exploding    out  1   state == EXPLODE (registered)
//  exp_start    out  1   one-cycle pulse on entry to EXPLODE
//  rgb_out      out  12  colour for the current pixel
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, counters 0, cell regs 0, btn_q 0.
//    bomb_on, exp_on, bomb_active, exploding, exp_start all 0; rgb_out 0.
//  - Edge detect: btn_q <= bomb_btn; press = bomb_btn & ~btn_q. Only rising edges count.
//  - Drop cell, 10-bit unsigned arithmetic:
//      cx = (x_b + 8  - 48) >> 4, range 0..32
//      cy = (y_b + 17 - 32) >> 4, range 0..25
//  - FSM states IDLE, FUSE, EXPLODE:
//      IDLE -> FUSE when press & !gameover. On that edge: latch cx/cy, cnt <= 0.
//        bomb_active is high on the following cycle.
//      FUSE: cnt increments each cycle. At cnt == FUSE_CNT-1: -> EXPLODE, cnt <= 0, exp_start = 1 for 1 cycle.
//      EXPLODE: cnt increments each cycle. At cnt == EXP_CNT-1: -> IDLE.
//      Press in FUSE or EXPLODE is ignored (one bomb at a time); it is not queued.
//      gameover in FUSE or EXPLODE: -> IDLE next edge, cnt <= 0, no exp_start.
//      gameover has priority over the terminal count in the same cycle.
//  - Pixel tile, combinational: in_arena = 48<=x<=575 & 32<=y<=447; px = (x-48)>>4; py = (y-32)>>4.
//  - bomb_on = FUSE & in_arena & px==cx & py==cy.
//  - exp_on = EXPLODE & in_arena & (centre | h_arm | v_arm):
//      centre: px==cx & py==cy
//      h_arm: py==cy & cy even & |px-cx| <= EXP_LEN
//      v_arm: px==cx & cx even & |py-cy| <= EXP_LEN
//      Pillars occupy tiles with both indices odd, so an arm is suppressed entirely when its row/column is a pillar row/column.
//      Arena clipping comes from in_arena; no wrap-around at tile 0 or 32/25.
//      Compute |d| with 11-bit signed differences.
//  - rgb_out:
//      exp_on  -> EXP_RGB
//      bomb_on -> (cnt[23] ? FLASH_RGB : BOMB_RGB)
//      else    -> 0
//      exp_on has priority. bomb_on and exp_on are never both 1.
//  - Zero added pixel latency: bomb_on, exp_on and rgb_out are combinational from x, y and registered state.
//  - Counter width 28 bits; sized for both default count values.
// TESTING (bench overrides FUSE_CNT=20, EXP_CNT=10)
//  1. Drop: reset, x_b=64, y_b=23 (cell 1,0), bomb_btn 0->1.
//     -> bomb_active=1 next cycle; bomb_on=1 for x=64..79, y=32..47.
//     -> exp_start pulses exactly 20 cycles after entry to FUSE.
//     -> exploding stays 1 for 10 cycles, then IDLE.
//  2. Cross: bomb at cell (2,2), x_b=72, y_b=47.
//     -> exp_on for px 0..4 at py=2 and py 0..4 at px=2.
//     -> exp_on=0 at (5,2), (2,5), (1,1).
//  3. Pillar suppression: bomb at cell (3,2).
//     -> horizontal arm px 1..5 lit; vertical arm absent, only (3,2) lit on column 3.
//  4. Edge clip: bomb at cell (0,0).
//     -> exp_on only for x>=48, y>=32; no lit pixels at x=570..575 (no wrap).
//  5. Held/repeat button: hold bomb_btn high through FUSE and EXPLODE.
//     -> no second bomb after return to IDLE until a new 0->1 edge.
//  6. Abort: gameover=1 mid-FUSE -> IDLE next edge, no exp_start.
//     Reset asserted mid-EXPLODE -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/bomb_module.sv
// Bomb placement and explosion for the arena: latches the tile under the player on a button
// edge, runs a fuse and then an explosion timer, and renders the bomb and the explosion cross.
module bomb_module #(
    parameter int          FUSE_CNT  = 150_000_000,
    parameter int          EXP_CNT   = 50_000_000,
    parameter int          EXP_LEN   = 2,
    parameter logic [11:0] BOMB_RGB  = 12'h222,
    parameter logic [11:0] FLASH_RGB = 12'hF00,
    parameter logic [11:0] EXP_RGB   = 12'hFA0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [9:0]  x_b,
    input  logic [9:0]  y_b,
    input  logic        bomb_btn,
    input  logic        gameover,
    output logic        bomb_on,
    output logic        exp_on,
    output logic        bomb_active,
    output logic        exploding,
    output logic        exp_start,
    output logic [11:0] rgb_out
);

    typedef enum logic [1:0] {IDLE, FUSE, EXPLODE} state_t;

    localparam logic [27:0]        FUSE_LAST = 28'(FUSE_CNT - 1);
    localparam logic [27:0]        EXP_LAST  = 28'(EXP_CNT - 1);
    localparam logic signed [10:0] ARM_LEN   = 11'(EXP_LEN);

    state_t      state_q;
    logic [27:0] cnt_q;
    logic [5:0]  cx_q, cy_q;
    logic [5:0]  cx_d, cy_d;
    logic        btn_q;
    logic        bomb_active_q, exploding_q, exp_start_q;
    logic        press;

    // Hitbox centre sits 8 px right and 17 px down from the sprite's top-left corner.
    assign cx_d  = 6'((x_b + 10'd8 - 10'd48) >> 4);
    assign cy_d  = 6'((y_b + 10'd17 - 10'd32) >> 4);
    assign press = bomb_btn & ~btn_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            btn_q         <= 1'b0;
            bomb_active_q <= 1'b0;
            exploding_q   <= 1'b0;
            exp_start_q   <= 1'b0;
        end else begin
            btn_q       <= bomb_btn;
            exp_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press && !gameover) begin
                        state_q       <= FUSE;
                        cx_q          <= cx_d;
                        cy_q          <= cy_d;
                        cnt_q         <= '0;
                        bomb_active_q <= 1'b1;
                    end
                end
                FUSE: begin
                    if (gameover) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        bomb_active_q <= 1'b0;
                    end else if (cnt_q == FUSE_LAST) begin
                        state_q       <= EXPLODE;
                        cnt_q         <= '0;
                        bomb_active_q <= 1'b0;
                        exploding_q   <= 1'b1;
                        exp_start_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 28'd1;
                    end
                end
                EXPLODE: begin
                    if (gameover || cnt_q == EXP_LAST) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        exploding_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 28'd1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    bomb_active_q <= 1'b0;
                    exploding_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bomb_active = bomb_active_q;
    assign exploding   = exploding_q;
    assign exp_start   = exp_start_q;

    logic               in_arena;
    logic [5:0]         px, py;
    logic signed [10:0] dx, dy, adx, ady;
    logic               centre, h_arm, v_arm;

    assign in_arena = (x >= 10'd48) && (x <= 10'd575) && (y >= 10'd32) && (y <= 10'd447);
    assign px       = 6'((x - 10'd48) >> 4);
    assign py       = 6'((y - 10'd32) >> 4);
    assign dx       = $signed({5'b0, px}) - $signed({5'b0, cx_q});
    assign dy       = $signed({5'b0, py}) - $signed({5'b0, cy_q});
    assign adx      = dx[10] ? -dx : dx;
    assign ady      = dy[10] ? -dy : dy;

    // Odd rows/columns hold pillars, which block the whole arm along them.
    assign centre = (px == cx_q) && (py == cy_q);
    assign h_arm  = (py == cy_q) && !cy_q[0] && (adx <= ARM_LEN);
    assign v_arm  = (px == cx_q) && !cx_q[0] && (ady <= ARM_LEN);

    assign bomb_on = bomb_active_q && in_arena && centre;
    assign exp_on  = exploding_q && in_arena && (centre || h_arm || v_arm);
    assign rgb_out = exp_on  ? EXP_RGB :
                     bomb_on ? (cnt_q[23] ? FLASH_RGB : BOMB_RGB) : 12'h000;

endmodule

// File: tb/tb_bomb_module.sv
// Directed bench for bomb_module with shortened fuse/explosion timers: pixel vector tables per
// scenario plus hand-written sequences for timing, held button, abort and asynchronous reset.
module tb_bomb_module;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y, x_b, y_b;
    logic        bomb_btn, gameover;
    logic        bomb_on, exp_on, bomb_active, exploding, exp_start;
    logic [11:0] rgb_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bomb_module #(
        .FUSE_CNT (20),
        .EXP_CNT  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .x_b         (x_b),
        .y_b         (y_b),
        .bomb_btn    (bomb_btn),
        .gameover    (gameover),
        .bomb_on     (bomb_on),
        .exp_on      (exp_on),
        .bomb_active (bomb_active),
        .exploding   (exploding),
        .exp_start   (exp_start),
        .rgb_out     (rgb_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          scen;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        bon;
        logic        eon;
        logic [11:0] rgb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input int vx, input int vy, input logic b, input logic e,
                       input logic [11:0] c);
        vec_t v;
        v.scen = s; v.px = 10'(vx); v.py = 10'(vy); v.bon = b; v.eon = e; v.rgb = c;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int s);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s) begin
                x = vecs[i].px;
                y = vecs[i].py;
                #1;
                $display("scen %0d x=%0d y=%0d bomb_on=%0b exp_on=%0b rgb=%h",
                         s, x, y, bomb_on, exp_on, rgb_out);
                check($sformatf("s%0d_bomb_on(%0d,%0d)", s, x, y), 32'(bomb_on), 32'(vecs[i].bon));
                check($sformatf("s%0d_exp_on(%0d,%0d)", s, x, y), 32'(exp_on), 32'(vecs[i].eon));
                check($sformatf("s%0d_rgb(%0d,%0d)", s, x, y), 32'(rgb_out), 32'(vecs[i].rgb));
            end
        end
    endtask

    task automatic drop(input int bx, input int by, input logic hold);
        x_b = 10'(bx);
        y_b = 10'(by);
        bomb_btn = 1'b1;
        tick(1);
        if (!hold) bomb_btn = 1'b0;
    endtask

    task automatic wait_explode();
        int k = 0;
        while (!exploding && k < 100) begin tick(1); k++; end
        check("explode_reached", 32'(exploding), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exploding || bomb_active) && k < 100) begin tick(1); k++; end
        check("idle_reached", 32'(exploding | bomb_active), 32'd0);
    endtask

    initial begin
        int start;

        // Scenario 1: bomb at cell (1,0), during FUSE.
        add(1, 64, 32, 1, 0, 12'h222);
        add(1, 79, 47, 1, 0, 12'h222);
        add(1, 72, 40, 1, 0, 12'h222);
        add(1, 80, 32, 0, 0, 12'h000);
        add(1, 63, 40, 0, 0, 12'h000);
        add(1, 64, 48, 0, 0, 12'h000);
        // Scenario 2: cross at cell (2,2), tile centres offset by 5 px.
        add(2, 53, 69, 0, 1, 12'hFA0);
        add(2, 69, 69, 0, 1, 12'hFA0);
        add(2, 85, 69, 0, 1, 12'hFA0);
        add(2, 101, 69, 0, 1, 12'hFA0);
        add(2, 117, 69, 0, 1, 12'hFA0);
        add(2, 85, 37, 0, 1, 12'hFA0);
        add(2, 85, 53, 0, 1, 12'hFA0);
        add(2, 85, 85, 0, 1, 12'hFA0);
        add(2, 85, 101, 0, 1, 12'hFA0);
        add(2, 133, 69, 0, 0, 12'h000);
        add(2, 85, 117, 0, 0, 12'h000);
        add(2, 69, 53, 0, 0, 12'h000);
        // Scenario 3: cell (3,2), column 3 is a pillar column.
        add(3, 69, 69, 0, 1, 12'hFA0);
        add(3, 85, 69, 0, 1, 12'hFA0);
        add(3, 101, 69, 0, 1, 12'hFA0);
        add(3, 117, 69, 0, 1, 12'hFA0);
        add(3, 133, 69, 0, 1, 12'hFA0);
        add(3, 53, 69, 0, 0, 12'h000);
        add(3, 149, 69, 0, 0, 12'h000);
        add(3, 101, 53, 0, 0, 12'h000);
        add(3, 101, 85, 0, 0, 12'h000);
        add(3, 101, 101, 0, 0, 12'h000);
        // Scenario 4: cell (0,0), arena clipping without wrap.
        add(4, 48, 32, 0, 1, 12'hFA0);
        add(4, 63, 47, 0, 1, 12'hFA0);
        add(4, 80, 32, 0, 1, 12'hFA0);
        add(4, 96, 32, 0, 0, 12'h000);
        add(4, 48, 64, 0, 1, 12'hFA0);
        add(4, 47, 32, 0, 0, 12'h000);
        add(4, 48, 31, 0, 0, 12'h000);
        add(4, 570, 32, 0, 0, 12'h000);
        add(4, 575, 32, 0, 0, 12'h000);
        add(4, 48, 447, 0, 0, 12'h000);

        reset = 1'b0; x = '0; y = '0; x_b = '0; y_b = '0; bomb_btn = 1'b0; gameover = 1'b0;
        #22;
        check("rst_bomb_active", 32'(bomb_active), 32'd0);
        check("rst_exploding", 32'(exploding), 32'd0);
        check("rst_exp_start", 32'(exp_start), 32'd0);
        check("rst_rgb", 32'(rgb_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick(2);

        // Scenario 1: drop and timing.
        check("s1_idle_before", 32'(bomb_active), 32'd0);
        drop(64, 23, 1'b0);
        start = cyc;
        check("s1_bomb_active", 32'(bomb_active), 32'd1);
        run_table(1);
        while (!exp_start && (cyc - start) < 100) tick(1);
        check("s1_fuse_cycles", 32'(cyc - start), 32'd20);
        check("s1_exploding_at_start", 32'(exploding), 32'd1);
        check("s1_fuse_over", 32'(bomb_active), 32'd0);
        start = cyc;
        tick(1);
        check("s1_exp_start_width", 32'(exp_start), 32'd0);
        while (exploding && (cyc - start) < 100) tick(1);
        check("s1_explode_cycles", 32'(cyc - start), 32'd10);
        wait_idle();

        drop(72, 47, 1'b0);
        wait_explode();
        run_table(2);
        wait_idle();

        drop(88, 47, 1'b0);
        wait_explode();
        run_table(3);
        wait_idle();

        drop(40, 15, 1'b0);
        wait_explode();
        run_table(4);
        wait_idle();

        // Scenario 5: held button must not re-arm.
        drop(72, 47, 1'b1);
        wait_explode();
        wait_idle();
        tick(5);
        check("s5_held_no_rearm", 32'(bomb_active), 32'd0);
        bomb_btn = 1'b0;
        tick(1);
        bomb_btn = 1'b1;
        tick(1);
        bomb_btn = 1'b0;
        check("s5_new_edge_arms", 32'(bomb_active), 32'd1);

        // Scenario 6a: gameover mid-FUSE aborts without an explosion.
        tick(5);
        gameover = 1'b1;
        tick(1);
        check("s6_abort_bomb_active", 32'(bomb_active), 32'd0);
        check("s6_abort_exp_start", 32'(exp_start), 32'd0);
        check("s6_abort_exploding", 32'(exploding), 32'd0);
        bomb_btn = 1'b1;
        tick(1);
        check("s6_gameover_blocks_drop", 32'(bomb_active), 32'd0);
        bomb_btn = 1'b0;
        gameover = 1'b0;
        tick(25);
        check("s6_no_late_explosion", 32'(exploding), 32'd0);

        // Scenario 6b: asynchronous reset mid-EXPLODE.
        drop(72, 47, 1'b0);
        wait_explode();
        x = 10'd85; y = 10'd69;
        #1;
        check("s6_exp_on_before_reset", 32'(exp_on), 32'd1);
        reset = 1'b0;
        #1;
        check("s6_rst_exploding", 32'(exploding), 32'd0);
        check("s6_rst_exp_on", 32'(exp_on), 32'd0);
        check("s6_rst_rgb", 32'(rgb_out), 32'd0);
        check("s6_rst_bomb_active", 32'(bomb_active), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
